// File: rtl/recovery_pkg.sv
// Shared types and helpers for the branch recovery sequencer.
package recovery_pkg;

    localparam int unsigned CP_AGE_MAX_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RECALL,
        DRAIN
    } recovery_state_t;

    typedef logic [CP_AGE_MAX_W-1:0] cp_age_t;

    // Age relative to the checkpointer head, wrapped to the live id width.
    function automatic cp_age_t cp_age(input cp_age_t id, input cp_age_t oldest,
                                       input int unsigned width);
        cp_age_t mask;
        mask = cp_age_t'((32'd1 << width) - 32'd1);
        return (id - oldest) & mask;
    endfunction

endpackage

// File: rtl/cp_age_select.sv
// Combinational oldest-of-N select: smallest age wins, lower lane wins ties.
module cp_age_select #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0]                          valid,
    input  logic [N-1:0][W-1:0]                   age,
    output logic                                  found,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  idx,
    output logic [W-1:0]                          age_min
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        found   = 1'b0;
        idx     = '0;
        age_min = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (valid[i] && (!found || age[i] < age_min)) begin
                found   = 1'b1;
                idx     = IW'(i);
                age_min = age[i];
            end
        end
    end

endmodule

// File: rtl/branch_recovery_sequencer.sv
// Misprediction recovery sequencer for rename: oldest-mispredict recall, drain stall, validation filter.
// Optional perf counters enabled by defining RECOVERY_PERF_CNT_EN.
module branch_recovery_sequencer
    import recovery_pkg::*;
#(
    parameter int unsigned NUM_BR       = 2,
    parameter int unsigned NUM_CP       = 8,
    parameter int unsigned AL_SIZE      = 32,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       ext_flush,
    input  logic [NUM_BR-1:0]                          br_valid,
    input  logic [NUM_BR-1:0]                          br_mispredict,
    input  logic [NUM_BR-1:0][$clog2(NUM_CP)-1:0]      br_cp_id,
    input  logic [NUM_BR-1:0][$clog2(AL_SIZE)-1:0]     br_al_idx,
    input  logic [NUM_BR-1:0][31:0]                    br_target,
    input  logic [$clog2(NUM_CP)-1:0]                  oldest_cp_id,
    output logic                                       recall_valid,
    output logic [$clog2(NUM_CP)-1:0]                  recall_cp_id,
    output logic [$clog2(AL_SIZE)-1:0]                 recall_al_front,
    output logic                                       redirect_valid,
    output logic [31:0]                                redirect_pc,
    output logic [NUM_BR-1:0]                          validate,
    output logic [NUM_BR-1:0][$clog2(NUM_CP)-1:0]      validated_id,
    output logic                                       rename_stall,
    output logic                                       busy,
    output logic [31:0]                                perf_recalls,
    output logic [31:0]                                perf_stall_cycles
);

    localparam int unsigned CP_W  = $clog2(NUM_CP);
    localparam int unsigned SEL_W = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;
    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    recovery_state_t             state;
    logic [CNT_W-1:0]            drain_cnt;
    logic [NUM_BR-1:0][CP_W-1:0] lane_age;
    logic [NUM_BR-1:0]           mispredict;
    logic [NUM_BR-1:0]           validation;
    logic [NUM_BR-1:0]           forward;
    logic                        cand_found;
    logic [SEL_W-1:0]            cand_idx;
    logic [CP_W-1:0]             cand_age;
    logic [CP_W-1:0]             active_age;
    logic                        recall_active;
    logic                        ref_found;
    logic [0:0]                  ref_idx;
    logic [CP_W-1:0]             ref_age;
    logic                        take;

    always_comb begin
        for (int unsigned i = 0; i < NUM_BR; i++) begin
            lane_age[i]   = CP_W'(cp_age(cp_age_t'(br_cp_id[i]), cp_age_t'(oldest_cp_id), CP_W));
            mispredict[i] = br_valid[i] & br_mispredict[i];
            validation[i] = br_valid[i] & ~br_mispredict[i];
        end
        active_age    = CP_W'(cp_age(cp_age_t'(recall_cp_id), cp_age_t'(oldest_cp_id), CP_W));
        recall_active = (state != IDLE);
    end

    cp_age_select #(.N(NUM_BR), .W(CP_W)) u_cand_select (
        .valid   (mispredict),
        .age     (lane_age),
        .found   (cand_found),
        .idx     (cand_idx),
        .age_min (cand_age)
    );

    // Lane 0 is the active recall so it wins age ties: the new winner takes over
    // only when strictly older. The same min age is the validation reference.
    cp_age_select #(.N(2), .W(CP_W)) u_ref_select (
        .valid   ({cand_found, recall_active}),
        .age     ({cand_age, active_age}),
        .found   (ref_found),
        .idx     (ref_idx),
        .age_min (ref_age)
    );

    always_comb begin
        take = ref_found && (ref_idx == 1'b1);
        for (int unsigned i = 0; i < NUM_BR; i++) begin
            forward[i] = validation[i] && (!ref_found || (lane_age[i] < ref_age));
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ext_flush) begin
            state           <= IDLE;
            drain_cnt       <= '0;
            recall_valid    <= 1'b0;
            redirect_valid  <= 1'b0;
            recall_cp_id    <= '0;
            recall_al_front <= '0;
            redirect_pc     <= '0;
            validate        <= '0;
            validated_id    <= '0;
            rename_stall    <= 1'b0;
            busy            <= 1'b0;
        end else begin
            validate <= forward;
            for (int unsigned i = 0; i < NUM_BR; i++) begin
                validated_id[i] <= forward[i] ? br_cp_id[i] : '0;
            end
            recall_valid   <= 1'b0;
            redirect_valid <= 1'b0;
            if (take) begin
                state           <= RECALL;
                drain_cnt       <= '0;
                recall_valid    <= 1'b1;
                redirect_valid  <= 1'b1;
                recall_cp_id    <= br_cp_id[cand_idx];
                recall_al_front <= br_al_idx[cand_idx];
                redirect_pc     <= br_target[cand_idx];
                rename_stall    <= 1'b1;
                busy            <= 1'b1;
            end else begin
                case (state)
                    RECALL: begin
                        state        <= DRAIN;
                        drain_cnt    <= CNT_W'(DRAIN_CYCLES - 1);
                        rename_stall <= 1'b1;
                        busy         <= 1'b1;
                    end
                    DRAIN: begin
                        if (drain_cnt == '0) begin
                            state        <= IDLE;
                            rename_stall <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state        <= IDLE;
                        rename_stall <= 1'b0;
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RECOVERY_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_recalls      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (recall_valid) perf_recalls <= perf_recalls + 32'd1;
            if (rename_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    assign perf_recalls      = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: doc/branch_recovery_sequencer.md
# branch_recovery_sequencer

Sequences misprediction recovery for the rename stage. Each cycle it takes up to `NUM_BR` branch resolutions from execute and selects the oldest mispredict by checkpoint age. It then drives a single recall pulse to the checkpointer, RMT, free list, active list and busy-bit table, and holds rename stalled while the restored state settles. It also filters checkpoint validations so that validations for squashed (younger) checkpoints never reach the checkpointer.

## Interface
Parameters:
- `NUM_BR`, default 2: branch resolutions per cycle.
- `NUM_CP`, default 8: checkpoint slots, power of two.
- `AL_SIZE`, default 32: active-list entries, power of two.
- `DRAIN_CYCLES`, default 2: stall cycles after the recall pulse, ≥1.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `ext_flush` in 1: commit/exception flush, highest priority.
- `br_valid[NUM_BR]` in 1: resolution valid.
- `br_mispredict[NUM_BR]` in 1: 1 = mispredicted, 0 = correct.
- `br_cp_id[NUM_BR]` in log2(NUM_CP): checkpoint of the resolving branch.
- `br_al_idx[NUM_BR]` in log2(AL_SIZE): active-list index of the branch.
- `br_target[NUM_BR]` in 32: correct next PC.
- `oldest_cp_id` in log2(NUM_CP): checkpointer head (oldest live slot).
- `recall_valid` out 1: one-cycle recall pulse.
- `recall_cp_id` out log2(NUM_CP): checkpoint to restore.
- `recall_al_front` out log2(AL_SIZE): new active-list front.
- `redirect_valid` out 1: fetch redirect; asserted in the same cycle as `recall_valid`.
- `redirect_pc` out 32: redirect target.
- `validate[NUM_BR]` out 1: forwarded validation.
- `validated_id[NUM_BR]` out log2(NUM_CP): forwarded validation id.
- `rename_stall` out 1: hold rename.
- `busy` out 1: FSM not in IDLE.
- `perf_recalls` out 32: recall count (see Configuration).
- `perf_stall_cycles` out 32: stall-cycle count (see Configuration).

## Operation
- Age of a checkpoint is `(cp_id - oldest_cp_id) mod NUM_CP`, computed in log2(NUM_CP) bits with natural wrap. A smaller age is older. On equal age, the lower port index wins.
- Candidate selection: among the lanes with `br_valid && br_mispredict`, the candidate is the oldest one.
- IDLE state:
  - If a candidate exists, latch its `cp_id`, `al_idx` and `target`, and go to RECALL.
  - Otherwise remain in IDLE.
- RECALL state, one cycle:
  - Assert `recall_valid`, `redirect_valid` and `rename_stall`.
  - Load the drain counter with `DRAIN_CYCLES-1`.
  - Go to DRAIN.
- DRAIN state:
  - Assert `rename_stall`.
  - Decrement the counter; at 0, go to IDLE.
- Feedback arriving while in RECALL or DRAIN:
  - Age is recomputed against the current `oldest_cp_id`.
  - A candidate strictly older than the active recall re-latches and restarts RECALL.
  - A candidate equal in age to, or younger than, the active recall is ignored.
- Validation filter, every state. Lane i is forwarded when `br_valid[i] && !br_mispredict[i]` and its age is strictly less than the reference age.
  - Reference age: the age of the winning candidate of this cycle, or of the active recall if there is no new winner.
  - When no recall is active and there is no candidate, every validation is forwarded.
- `ext_flush`:
  - Forces IDLE and clears the counter and latched state.
  - Suppresses `recall_valid`, `redirect_valid` and `validate` for the feedback sampled in that cycle.
- `reset`: same effect as `ext_flush`.
  - Every output resets to 0: `recall_*`, `redirect_*`, `validate`, `validated_id`, `rename_stall`, `busy`.
  - The perf counters also reset to 0.

## Timing
- All outputs are registered. Feedback sampled at edge N produces `recall_valid`, `redirect_valid` and `validate` at edge N+1.
- `rename_stall` stays high for exactly `1 + DRAIN_CYCLES` cycles per uninterrupted recovery, starting with the RECALL cycle.
- A restart extends the stall: the full `1 + DRAIN_CYCLES` is counted again from the new RECALL cycle.
- Back-to-back recoveries: a new candidate sampled on the last DRAIN cycle is older-only by the restart rule. A candidate sampled in IDLE starts immediately, with no dead cycle required.
- `busy` equals `state != IDLE`, registered.

## Configuration
- `RECOVERY_PERF_CNT_EN` defined:
  - `perf_recalls` increments on each `recall_valid`.
  - `perf_stall_cycles` increments on each cycle with `rename_stall`.
  - Both are 32-bit, wrap, and are cleared by `reset` only; `ext_flush` does not clear them.
- Undefined: both ports are constant 0 and no counter flops exist.

## Structure
- Shared package `recovery_pkg` holds:
  - `recovery_state_t` (IDLE, RECALL, DRAIN).
  - `cp_age_t` width typedef.
  - Function `cp_age(id, oldest)`.
- One sub-module, `cp_age_select`: combinational oldest-of-N selection over the lane valids and ages. It outputs the winner index, a found flag and the winner age. It is reused by the validation filter for the reference age.

## Test plan
All scenarios use `NUM_BR=2`, `NUM_CP=8`, `DRAIN_CYCLES=2`.
1. Reset held 3 cycles, then released with no feedback -> all outputs 0 and `busy=0` for 5 cycles.
2. Lane0 mispredict, cp=3, al=10, target=0x400, oldest=1 -> next cycle `recall_valid=1`, `recall_cp_id=3`, `recall_al_front=10`, `redirect_pc=0x400`; `rename_stall` high for 3 cycles, then `busy=0`.
3. Wrap-around: lane0 mispredict cp=2, lane1 mispredict cp=6, oldest=5 (ages 5 and 1) -> `recall_cp_id=6`, target taken from lane1.
4. Filter, oldest=0: lane0 validate cp=2, lane1 mispredict cp=4 -> `validate[0]=1`, `validated_id[0]=2`, recall of cp 4. Same stimulus with lane0 validate cp=5 -> `validate[0]=0`.
5. Restart: recall of cp=5 active (oldest=0) and in DRAIN.
   - An older mispredict cp=3 arrives -> next cycle `recall_valid=1` with `recall_cp_id=3`, and the stall is counted again for 3 cycles.
   - A younger mispredict cp=7 arriving in DRAIN is ignored.
6. `ext_flush` asserted in the first DRAIN cycle, together with a mispredict cp=1 -> next cycle `rename_stall=0`, `busy=0`, no `recall_valid`.
   - With `RECOVERY_PERF_CNT_EN` defined, `perf_recalls` is unchanged by the flush.
